// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-N-1 UART transmitter, LSB first, with a byte FIFO in
// front of the serialiser. Bytes enter through a valid/ready handshake and are
// sent back-to-back while the FIFO holds data.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit (8-E-1, 11-bit frame).
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 1736,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                             i_Clock,
   input  logic                             i_Rst_N,
   input  logic                             i_Tx_DV,
   input  logic [7:0]                       i_Tx_Byte,
   output logic                             o_Tx_Ready,
   output logic                             o_Tx_Serial,
   output logic                             o_Tx_Active,
   output logic                             o_Tx_Done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_Fifo_Count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TC   = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      s_IDLE   = 3'd0,
      s_START  = 3'd1,
      s_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      s_PARITY = 3'd3,
`endif
      s_STOP   = 3'd4
   } state_t;

   // FIFO storage and pointers
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          nempty_q;
   logic          push, pop;

   // Serialiser state
   state_t        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          serial_q, serial_d;

   // FIFO bookkeeping: a write needs a non-full registered count, so a pop in
   // the same cycle never lets a full FIFO accept a byte.
   always_comb begin
      push     = i_Tx_DV && (count_q != FULL);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Frame sequencer: next state, bit timer, bit index and line level.
   // The idle pop waits on a registered non-empty flag, so a byte written
   // into an empty FIFO starts its frame two edges after it was accepted.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         s_IDLE: begin
            if (nempty_q && (count_q != '0)) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               cnt_d   = '0;
               idx_d   = '0;
               state_d = s_START;
            end
         end
         s_START: begin
            if (cnt_q == TC) begin
               cnt_d   = '0;
               state_d = s_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         s_DATA: begin
            if (cnt_q == TC) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = s_PARITY;
`else
                  state_d = s_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         s_PARITY: begin
            if (cnt_q == TC) begin
               cnt_d   = '0;
               state_d = s_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         s_STOP: begin
            if (cnt_q == TC) begin
               cnt_d   = '0;
               state_d = s_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = s_IDLE;
         end
      endcase

      // Line level follows the state being entered so the register lines up
      // with state_q, Active and Done.
      case (state_d)
         s_START:  serial_d = 1'b0;
         s_DATA:   serial_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
         s_PARITY: serial_d = ^shift_d;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

   // Control registers; reset aborts any frame and discards queued bytes.
   always_ff @(posedge i_Clock or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         nempty_q <= 1'b0;
         state_q  <= s_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         serial_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         nempty_q <= (count_q != '0);
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         serial_q <= serial_d;
      end
   end

   // Data storage: FIFO entries and the shift register holding the byte on the line.
   always_ff @(posedge i_Clock) begin
      if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
      shift_q <= shift_d;
   end

   assign o_Tx_Ready   = (count_q != FULL);
   assign o_Tx_Serial  = serial_q;
   assign o_Tx_Active  = (state_q != s_IDLE);
   assign o_Tx_Done    = (state_q == s_STOP) && (cnt_q == TC);
   assign o_Fifo_Count = count_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter with CLKS_PER_BIT=8 and FIFO_DEPTH=4.
// Directed scenarios: reset/idle, single byte, back-to-back, FIFO full,
// reset mid-frame, and (when UART_TX_PARITY_EN is defined) the parity bit.
module tb_uart_transmitter;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CPB;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          dv      = 1'b0;
   logic [7:0]    tx_byte = 8'h00;
   logic          ready, serial, active, done;
   logic [CW-1:0] count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .i_Clock      (clk),
      .i_Rst_N      (rst_n),
      .i_Tx_DV      (dv),
      .i_Tx_Byte    (tx_byte),
      .o_Tx_Ready   (ready),
      .o_Tx_Serial  (serial),
      .o_Tx_Active  (active),
      .o_Tx_Done    (done),
      .o_Fifo_Count (count)
   );

   // Waveform capture buffers, filled one sample per falling edge
   logic          ser_w  [0:511];
   logic          done_w [0:511];
   logic          act_w  [0:511];
   logic [CW-1:0] cnt_w  [0:511];

   // Independent line receiver: samples mid-bit, queues decoded bytes
   logic [7:0] rx_q[$];
   logic       par_q[$];
   int         mon_idx  = 0;
   int         mon_k    = 0;
   bit         mon_busy = 1'b0;
   logic [7:0] mon_byte = 8'h00;
   logic       mon_par  = 1'b0;
   int         done_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_busy = 1'b0;
         mon_idx  = 0;
      end else begin
         if (done === 1'b1) done_cnt++;
         if (!mon_busy) begin
            if (serial === 1'b0) begin
               mon_busy = 1'b1;
               mon_idx  = 0;
            end
         end else begin
            mon_idx++;
            if ((mon_idx % CPB) == (CPB / 2)) begin
               mon_k = mon_idx / CPB;
               if (mon_k >= 1 && mon_k <= 8) mon_byte[mon_k-1] = serial;
               else if (mon_k == 9 && NB == 11) mon_par = serial;
               if (mon_k == NB - 1) begin
                  rx_q.push_back(mon_byte);
                  par_q.push_back(mon_par);
                  mon_busy = 1'b0;
               end
            end
         end
      end
   end

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9 && NB == 11) return ^b;
      return 1'b1;
   endfunction

   task automatic record(input int n);
      for (int i = 0; i < n; i++) begin
         ser_w[i]  = serial;
         done_w[i] = done;
         act_w[i]  = active;
         cnt_w[i]  = count;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int lows = 0, dones = 0, notrdy = 0, nzcnt = 0;
      rst_n = 1'b0;
      dv    = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (serial !== 1'b1) begin n_bad++; $display("FAIL rst_serial got=%b exp=1", serial); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", ready); end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
      n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL rst_active got=%b exp=0", active); end
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (serial !== 1'b1) lows++;
         if (done !== 1'b0) dones++;
         if (ready !== 1'b1) notrdy++;
         if (count !== '0) nzcnt++;
      end
      n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL idle_serial low_cycles=%0d exp=0", lows); end
      n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL idle_done pulses=%0d exp=0", dones); end
      n_cmp++; if (notrdy != 0) begin n_bad++; $display("FAIL idle_ready notready_cycles=%0d exp=0", notrdy); end
      n_cmp++; if (nzcnt != 0) begin n_bad++; $display("FAIL idle_count nonzero_cycles=%0d exp=0", nzcnt); end
   endtask

   task automatic test_single();
      logic [CPB-1:0] seg;
      logic           e;
      int             dn = 0, hi = 0;
      dv = 1'b1; tx_byte = 8'hA5;
      @(posedge clk);
      @(negedge clk);
      dv = 1'b0;
      n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("FAIL single_cnt_n got=%0d exp=1", count); end
      n_cmp++; if (serial !== 1'b1) begin n_bad++; $display("FAIL single_ser_n got=%b exp=1", serial); end
      @(negedge clk);
      n_cmp++; if (serial !== 1'b1) begin n_bad++; $display("FAIL single_ser_n1 got=%b exp=1", serial); end
      @(negedge clk);
      n_cmp++; if (serial !== 1'b0) begin n_bad++; $display("FAIL single_start_n2 got=%b exp=0", serial); end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL single_cnt_pop got=%0d exp=0", count); end
      record(FL + 20);
      for (int k = 0; k < NB; k++) begin
         e = frame_bit(8'hA5, k);
         for (int j = 0; j < CPB; j++) seg[j] = ser_w[k*CPB + j];
         n_cmp++; if (seg !== {CPB{e}}) begin n_bad++; $display("FAIL single_bit%0d got=%b exp=%b", k, seg, {CPB{e}}); end
      end
      for (int i = 0; i < FL + 20; i++) if (done_w[i] === 1'b1) dn++;
      for (int i = FL; i < FL + 20; i++) if (ser_w[i] === 1'b1) hi++;
      n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL single_done_count got=%0d exp=1", dn); end
      n_cmp++; if (done_w[FL-1] !== 1'b1) begin n_bad++; $display("FAIL single_done_pos got=%b exp=1", done_w[FL-1]); end
      n_cmp++; if (hi != 20) begin n_bad++; $display("FAIL single_idle_after high=%0d exp=20", hi); end
      n_cmp++; if (act_w[0] !== 1'b1) begin n_bad++; $display("FAIL single_act_first got=%b exp=1", act_w[0]); end
      n_cmp++; if (act_w[FL-1] !== 1'b1) begin n_bad++; $display("FAIL single_act_last got=%b exp=1", act_w[FL-1]); end
      n_cmp++; if (act_w[FL] !== 1'b0) begin n_bad++; $display("FAIL single_act_end got=%b exp=0", act_w[FL]); end
   endtask

   task automatic test_back_to_back();
      logic [CPB-1:0] seg;
      logic           e;
      int             hi = 0;
      dv = 1'b1; tx_byte = 8'h00;
      @(posedge clk);
      @(negedge clk);
      tx_byte = 8'hFF;
      n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("FAIL b2b_cnt_a got=%0d exp=1", count); end
      @(posedge clk);
      @(negedge clk);
      dv = 1'b0;
      n_cmp++; if (count !== CW'(2)) begin n_bad++; $display("FAIL b2b_cnt_b got=%0d exp=2", count); end
      @(negedge clk);
      n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("FAIL b2b_cnt_c got=%0d exp=1", count); end
      n_cmp++; if (serial !== 1'b0) begin n_bad++; $display("FAIL b2b_start got=%b exp=0", serial); end
      record(2*FL + 11);
      for (int k = 0; k < NB; k++) begin
         e = frame_bit(8'h00, k);
         for (int j = 0; j < CPB; j++) seg[j] = ser_w[k*CPB + j];
         n_cmp++; if (seg !== {CPB{e}}) begin n_bad++; $display("FAIL b2b_f1_bit%0d got=%b exp=%b", k, seg, {CPB{e}}); end
         e = frame_bit(8'hFF, k);
         for (int j = 0; j < CPB; j++) seg[j] = ser_w[FL + 1 + k*CPB + j];
         n_cmp++; if (seg !== {CPB{e}}) begin n_bad++; $display("FAIL b2b_f2_bit%0d got=%b exp=%b", k, seg, {CPB{e}}); end
      end
      n_cmp++; if (ser_w[FL] !== 1'b1) begin n_bad++; $display("FAIL b2b_gap got=%b exp=1", ser_w[FL]); end
      n_cmp++; if (cnt_w[FL] !== CW'(1)) begin n_bad++; $display("FAIL b2b_cnt_gap got=%0d exp=1", cnt_w[FL]); end
      n_cmp++; if (cnt_w[FL+1] !== '0) begin n_bad++; $display("FAIL b2b_cnt_end got=%0d exp=0", cnt_w[FL+1]); end
      for (int i = 2*FL + 1; i < 2*FL + 11; i++) if (ser_w[i] === 1'b1) hi++;
      n_cmp++; if (hi != 10) begin n_bad++; $display("FAIL b2b_idle_after high=%0d exp=10", hi); end
   endtask

   task automatic test_fill();
      logic [7:0] exp_b [5];
      int         waited = 0, seen3c = 0;
      exp_b = '{8'h81, 8'h12, 8'h34, 8'h56, 8'h78};
      rx_q.delete();
      par_q.delete();
      done_cnt = 0;
      dv = 1'b1; tx_byte = exp_b[0];
      @(posedge clk);
      @(negedge clk);
      dv = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL fill_inflight got=%b exp=1", active); end
      for (int i = 1; i < 5; i++) begin
         dv = 1'b1; tx_byte = exp_b[i];
         @(posedge clk);
         @(negedge clk);
      end
      dv = 1'b0;
      n_cmp++; if (count !== CW'(4)) begin n_bad++; $display("FAIL fill_count got=%0d exp=4", count); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready got=%b exp=0", ready); end
      dv = 1'b1; tx_byte = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      dv = 1'b0;
      n_cmp++; if (count !== CW'(4)) begin n_bad++; $display("FAIL fill_drop_count got=%0d exp=4", count); end
      while (rx_q.size() < 5 && waited < 6*(FL + 1) + 50) begin
         @(negedge clk);
         waited++;
      end
      repeat (3*FL) @(negedge clk);
      n_cmp++; if (rx_q.size() != 5) begin n_bad++; $display("FAIL fill_frames got=%0d exp=5", rx_q.size()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= rx_q.size()) begin n_bad++; $display("FAIL fill_byte%0d got=none exp=%02h", i, exp_b[i]); end
         else if (rx_q[i] !== exp_b[i]) begin n_bad++; $display("FAIL fill_byte%0d got=%02h exp=%02h", i, rx_q[i], exp_b[i]); end
      end
      foreach (rx_q[i]) if (rx_q[i] === 8'h3C) seen3c++;
      n_cmp++; if (seen3c != 0) begin n_bad++; $display("FAIL fill_no3c got=%0d exp=0", seen3c); end
      n_cmp++; if (done_cnt != 5) begin n_bad++; $display("FAIL fill_done got=%0d exp=5", done_cnt); end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL fill_final_count got=%0d exp=0", count); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL fill_final_ready got=%b exp=1", ready); end
   endtask

   task automatic test_reset_mid();
      int lows = 0;
      rx_q.delete();
      par_q.delete();
      done_cnt = 0;
      dv = 1'b1; tx_byte = 8'h5A;
      @(posedge clk); @(negedge clk);
      tx_byte = 8'h11;
      @(posedge clk); @(negedge clk);
      tx_byte = 8'h22;
      @(posedge clk); @(negedge clk);
      dv = 1'b0;
      n_cmp++; if (count !== CW'(2)) begin n_bad++; $display("FAIL mid_queued got=%0d exp=2", count); end
      n_cmp++; if (serial !== 1'b0) begin n_bad++; $display("FAIL mid_start got=%b exp=0", serial); end
      repeat (36) @(negedge clk);
      n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL mid_active got=%b exp=1", active); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (serial !== 1'b1) begin n_bad++; $display("FAIL mid_rst_serial got=%b exp=1", serial); end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
      n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL mid_rst_active got=%b exp=0", active); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (serial !== 1'b1) lows++;
      end
      n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL mid_after_low got=%0d exp=0", lows); end
      n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL mid_frames got=%0d exp=0", rx_q.size()); end
      n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL mid_done got=%0d exp=0", done_cnt); end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL mid_after_count got=%0d exp=0", count); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [CPB-1:0] seg;
      logic           e;
      dv = 1'b1; tx_byte = 8'h07;
      @(posedge clk);
      @(negedge clk);
      dv = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (serial !== 1'b0) begin n_bad++; $display("FAIL par_start got=%b exp=0", serial); end
      record(FL + 5);
      for (int k = 0; k < NB; k++) begin
         e = frame_bit(8'h07, k);
         for (int j = 0; j < CPB; j++) seg[j] = ser_w[k*CPB + j];
         n_cmp++; if (seg !== {CPB{e}}) begin n_bad++; $display("FAIL par_bit%0d got=%b exp=%b", k, seg, {CPB{e}}); end
      end
      for (int j = 0; j < CPB; j++) seg[j] = ser_w[9*CPB + j];
      n_cmp++; if (seg !== {CPB{1'b1}}) begin n_bad++; $display("FAIL par_parity got=%b exp=%b", seg, {CPB{1'b1}}); end
      n_cmp++; if (done_w[87] !== 1'b1) begin n_bad++; $display("FAIL par_done88 got=%b exp=1", done_w[87]); end
      n_cmp++; if (act_w[88] !== 1'b0) begin n_bad++; $display("FAIL par_len got=%b exp=0", act_w[88]); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time_limit_reached exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
